// File: rtl/dbg_prog_loader.sv
// ---------------------------------------------------------------------------
// dbg_prog_loader - streams host words into the core debug write port, holds the core in reset while loading
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dbg_prog_loader #(
   parameter int XLEN           = 32,
   parameter int MEM_DEPTH      = 256,
   parameter int RELEASE_CYCLES = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           load_start,
   input  logic [XLEN-1:0]                base_addr,
   input  logic                           s_valid,
   output logic                           s_ready,
   input  logic [XLEN-1:0]                s_data,
   input  logic                           s_last,
   output logic                           dbg_wr_en,
   output logic [XLEN-1:0]                dbg_addr,
   output logic [XLEN-1:0]                dbg_instr,
   output logic                           core_rst,
   output logic                           busy,
   output logic                           done,
   output logic                           err,
   output logic [$clog2(MEM_DEPTH+1)-1:0] word_count,
   output logic [XLEN-1:0]                checksum
);

   localparam int WC_W = $clog2(MEM_DEPTH+1);
   localparam int RC_W = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;
   localparam logic [RC_W-1:0] RC_LAST    = RC_W'(RELEASE_CYCLES-1);
   localparam logic [XLEN-1:0] ADDR_LIMIT = XLEN'(4*MEM_DEPTH);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_LOAD    = 3'd1;
   localparam logic [2:0] S_SETUP   = 3'd2;
   localparam logic [2:0] S_WRITE   = 3'd3;
   localparam logic [2:0] S_HOLD    = 3'd4;
   localparam logic [2:0] S_RELEASE = 3'd5;
   localparam logic [2:0] S_RUN     = 3'd6;
   localparam logic [2:0] S_ERROR   = 3'd7;

   logic [2:0]      state, state_nxt;
   logic [XLEN-1:0] next_addr;
   logic [XLEN-1:0] addr_after;
   logic            last_q;
   logic [RC_W-1:0] rel_cnt;
   logic            start_ok;

   assign start_ok   = (base_addr[1:0] == 2'b00) && (base_addr < ADDR_LIMIT);
   assign addr_after = next_addr + XLEN'(4);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   // load_start overrides every state, including an in-flight write
   always_comb begin
      state_nxt = state;
      if (load_start) begin
         state_nxt = start_ok ? S_LOAD : S_ERROR;
      end else begin
         case (state)
            S_LOAD:    if (s_valid) state_nxt = S_SETUP;
            S_SETUP:   state_nxt = S_WRITE;
            S_WRITE:   state_nxt = S_HOLD;
            S_HOLD: begin
               if (last_q)                        state_nxt = S_RELEASE;
               else if (addr_after >= ADDR_LIMIT) state_nxt = S_ERROR;
               else                               state_nxt = S_LOAD;
            end
            S_RELEASE: if (rel_cnt == RC_LAST) state_nxt = S_RUN;
            default:   state_nxt = state;
         endcase
      end
   end

   always_comb begin
      s_ready   = (state == S_LOAD);
      dbg_wr_en = (state == S_WRITE);
      core_rst  = (state != S_RUN);
      done      = (state == S_RUN);
      err       = (state == S_ERROR);
      busy      = (state == S_LOAD) || (state == S_SETUP) || (state == S_WRITE) ||
                  (state == S_HOLD) || (state == S_RELEASE);
   end

   // dbg_instr doubles as the captured-word register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         next_addr  <= '0;
         last_q     <= 1'b0;
         rel_cnt    <= '0;
         dbg_addr   <= '0;
         dbg_instr  <= '0;
         word_count <= '0;
         checksum   <= '0;
      end else if (load_start) begin
         if (start_ok) begin
            next_addr  <= base_addr;
            word_count <= '0;
            checksum   <= '0;
         end
      end else begin
         case (state)
            S_LOAD: begin
               if (s_valid) begin
                  dbg_addr  <= next_addr;
                  dbg_instr <= s_data;
                  last_q    <= s_last;
               end
            end
            S_HOLD: begin
               word_count <= word_count + WC_W'(1);
               checksum   <= checksum + dbg_instr;
               next_addr  <= addr_after;
               rel_cnt    <= '0;
            end
            S_RELEASE: rel_cnt <= rel_cnt + RC_W'(1);
            default: ;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_dbg_prog_loader.sv
// ---------------------------------------------------------------------------
// tb_dbg_prog_loader - directed bench for dbg_prog_loader (256-word and 4-word instances)
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_dbg_prog_loader;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        load_start = 1'b0;
   logic [31:0] base_addr = '0;
   logic        s_valid = 1'b0;
   logic [31:0] s_data = '0;
   logic        s_last = 1'b0;

   logic        s_ready, dbg_wr_en, core_rst, busy, done, err;
   logic [31:0] dbg_addr, dbg_instr, checksum;
   logic [8:0]  word_count;

   logic        s_ready2, dbg_wr_en2, core_rst2, busy2, done2, err2;
   logic [31:0] dbg_addr2, dbg_instr2, checksum2;
   logic [2:0]  word_count2;

   int compared = 0;
   int mismatched = 0;
   int cyc = 0;

   logic [31:0] wa[$], wd[$], wa2[$];
   int          wt[$];
   logic [31:0] words[3] = '{32'h00C00093, 32'h00200113, 32'h0000DC63};

   dbg_prog_loader #(.XLEN(32), .MEM_DEPTH(256), .RELEASE_CYCLES(4)) dut (
      .clk(clk), .rst(rst), .load_start(load_start), .base_addr(base_addr),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
      .dbg_wr_en(dbg_wr_en), .dbg_addr(dbg_addr), .dbg_instr(dbg_instr),
      .core_rst(core_rst), .busy(busy), .done(done), .err(err),
      .word_count(word_count), .checksum(checksum));

   dbg_prog_loader #(.XLEN(32), .MEM_DEPTH(4), .RELEASE_CYCLES(4)) dut2 (
      .clk(clk), .rst(rst), .load_start(load_start), .base_addr(base_addr),
      .s_valid(s_valid), .s_ready(s_ready2), .s_data(s_data), .s_last(s_last),
      .dbg_wr_en(dbg_wr_en2), .dbg_addr(dbg_addr2), .dbg_instr(dbg_instr2),
      .core_rst(core_rst2), .busy(busy2), .done(done2), .err(err2),
      .word_count(word_count2), .checksum(checksum2));

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (dbg_wr_en) begin
         wa.push_back(dbg_addr);
         wd.push_back(dbg_instr);
         wt.push_back(cyc);
      end
      if (dbg_wr_en2) wa2.push_back(dbg_addr2);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start(input logic [31:0] a);
      load_start = 1'b1;
      base_addr  = a;
      tick();
      load_start = 1'b0;
   endtask

   task automatic send(input logic [31:0] d, input logic l);
      s_valid = 1'b1;
      s_data  = d;
      s_last  = l;
      for (int i = 0; i < 20 && !s_ready; i++) tick();
      chk("ready_wait", {31'd0, s_ready}, 32'd1);
      tick();
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   initial begin
      int idx;
      logic acc;

      // reset values
      #2;
      chk("rst_core_rst", {31'd0, core_rst}, 32'd1);
      chk("rst_flags", {28'd0, s_ready, busy, done, err}, 32'd0);
      chk("rst_dbg", {31'd0, dbg_wr_en} | dbg_addr | dbg_instr, 32'd0);
      chk("rst_counts", {23'd0, word_count} | checksum, 32'd0);
      tick(); tick();
      rst = 1'b1;
      tick();

      // basic three-word load from 4
      wa.delete(); wd.delete(); wt.delete();
      start(32'd4);
      chk("t1_load", {30'd0, s_ready, busy}, 32'd3);
      send(words[0], 1'b0);
      chk("t1_setup_addr", dbg_addr, 32'd4);
      chk("t1_setup_data", dbg_instr, words[0]);
      chk("t1_setup_wr", {31'd0, dbg_wr_en}, 32'd0);
      tick();
      chk("t1_write_wr", {31'd0, dbg_wr_en}, 32'd1);
      tick();
      chk("t1_hold", {31'd0, dbg_wr_en} | {23'd0, word_count}, 32'd0);
      chk("t1_hold_addr", dbg_addr, 32'd4);
      tick();
      chk("t1_wc1", {23'd0, word_count}, 32'd1);
      chk("t1_cs1", checksum, words[0]);
      send(words[1], 1'b0);
      send(words[2], 1'b1);
      tick(); tick();
      chk("t1_hold3_core_rst", {31'd0, core_rst}, 32'd1);
      tick(); tick(); tick(); tick();
      chk("t1_rel4", {29'd0, core_rst, done, busy}, 32'b101);
      tick();
      chk("t1_run", {29'd0, core_rst, done, busy}, 32'b010);
      chk("t1_wc", {23'd0, word_count}, 32'd3);
      chk("t1_cs", checksum, 32'h00E0DE09);
      chk("t1_nwrites", wa.size(), 32'd3);
      chk("t1_addrs", {wa[0][7:0], wa[1][7:0], wa[2][7:0]}, 32'h0004080C);
      chk("t1_data2", wd[2], words[2]);
      chk("t1_gap01", wt[1] - wt[0], 32'd4);
      chk("t1_gap12", wt[2] - wt[1], 32'd4);

      // same load with s_valid toggling
      wa.delete(); wd.delete(); wt.delete();
      start(32'd4);
      idx = 0;
      for (int c = 0; c < 80 && idx < 3; c++) begin
         s_valid = c[0];
         s_data  = words[idx];
         s_last  = (idx == 2);
         acc     = s_valid && s_ready;
         tick();
         if (acc) idx++;
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
      for (int i = 0; i < 30 && !done; i++) tick();
      chk("t2_done", {31'd0, done}, 32'd1);
      chk("t2_wc", {23'd0, word_count}, 32'd3);
      chk("t2_cs", checksum, 32'h00E0DE09);
      chk("t2_nwrites", wa.size(), 32'd3);
      chk("t2_addrs", {wa[0][7:0], wa[1][7:0], wa[2][7:0]}, 32'h0004080C);
      chk("t2_data", wd[0] ^ wd[1] ^ wd[2], words[0] ^ words[1] ^ words[2]);

      // 4-word memory overrun, then legal last word at final address
      wa2.delete();
      start(32'd8);
      send(32'h11111111, 1'b0);
      send(32'h22222222, 1'b0);
      tick(); tick();
      chk("t3_hold_err", {31'd0, err2}, 32'd0);
      tick();
      chk("t3_err", {29'd0, err2, core_rst2, busy2}, 32'b110);
      chk("t3_wc", {29'd0, word_count2}, 32'd2);
      chk("t3_nwrites", wa2.size(), 32'd2);
      chk("t3_addrs", {wa2[0][15:0], wa2[1][15:0]}, 32'h0008000C);
      start(32'd12);
      chk("t3b_ready", {31'd0, s_ready2}, 32'd1);
      send(32'h33333333, 1'b1);
      for (int i = 0; i < 8; i++) tick();
      chk("t3b_run", {29'd0, done2, err2, core_rst2}, 32'b100);
      chk("t3b_wc", {29'd0, word_count2}, 32'd1);

      // misaligned and out-of-range start addresses
      start(32'd6);
      chk("t4_err", {28'd0, err, busy, core_rst, s_ready}, 32'b1010);
      wa.delete();
      tick(); tick(); tick(); tick();
      chk("t4_nostrobe", wa.size(), 32'd0);
      start(32'd0);
      chk("t4_clear", {30'd0, err, s_ready}, 32'b01);
      start(32'd16);
      chk("t4_range", {30'd0, err2, busy}, 32'b11);

      // restart during the second word's WRITE cycle
      start(32'd0);
      send(32'hAAAA0001, 1'b0);
      tick(); tick(); tick();
      send(32'hAAAA0002, 1'b0);
      tick();
      chk("t5_write", {31'd0, dbg_wr_en}, 32'd1);
      chk("t5_wc_before", {23'd0, word_count}, 32'd1);
      load_start = 1'b1;
      base_addr  = 32'h40;
      tick();
      load_start = 1'b0;
      chk("t5_abandon", {30'd0, dbg_wr_en, s_ready}, 32'b01);
      chk("t5_cleared", {23'd0, word_count} | checksum, 32'd0);
      send(32'hBBBB0003, 1'b1);
      tick(); tick();
      chk("t5_addr", wa[wa.size()-1], 32'h40);
      chk("t5_data", wd[wd.size()-1], 32'hBBBB0003);
      tick();
      chk("t5_wc", {23'd0, word_count}, 32'd1);
      chk("t5_cs", checksum, 32'hBBBB0003);

      // asynchronous reset during RELEASE
      chk("t6_in_release", {30'd0, busy, core_rst}, 32'b11);
      rst = 1'b0;
      #2;
      chk("t6_async", {29'd0, core_rst, busy, done}, 32'b100);
      chk("t6_counts", {23'd0, word_count} | checksum | dbg_addr, 32'd0);
      #1;
      rst = 1'b1;
      for (int i = 0; i < 8; i++) tick();
      chk("t6_idle", {28'd0, core_rst, busy, done, s_ready}, 32'b1000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

`default_nettype wire
